pipe_add_rv: RTL and testbench

Parametrised, carry-split pipelined adder with full valid/ready flow control. It is the successor to the fixed 32-bit, valid-only add pipeline. It accepts operand pairs on a ready/valid input, splits the addition into `STAGES` carry-propagating chunks (one chunk per register stage), and returns the sum on a ready/valid output with bubble-collapsing backpressure. It sits between datapath producers and consumers wherever a wide add must close timing at high clock rates.

---
 rtl/pipe_add_pkg.sv | 37 +++
 rtl/pipe_add_stage.sv | 104 ++++++++++
 rtl/pipe_add_rv.sv | 113 +++++++++++
 tb/tb_pipe_add_rv.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_add_pkg.sv
// pipe_add_pkg: shared helpers for the carry-split pipelined adder.
// Holds the chunk geometry, the latency figure and the parameter-legality test.
package pipe_add_pkg;

    // Bits per carry chunk: ceil(width / stages).
    function automatic int chunk_width(input int width, input int stages);
        if (stages < 1) begin
            return width;
        end
        return (width + stages - 1) / stages;
    endfunction

    // Register stages from operand capture to a visible result.
    function automatic int latency(input int stages);
        return stages + 1;
    endfunction

    // Lowest bit covered by chunk idx. Clamped to width so trailing chunks may be empty.
    function automatic int chunk_lo(input int width, input int cw, input int idx);
        int lo;
        lo = idx * cw;
        return (lo > width) ? width : lo;
    endfunction

    // One past the highest bit covered by chunk idx.
    function automatic int chunk_hi(input int width, input int cw, input int idx);
        int hi;
        hi = (idx + 1) * cw;
        return (hi > width) ? width : hi;
    endfunction

    // Legal shapes: at least one bit and 1 <= stages <= width.
    function automatic bit params_legal(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && (stages <= width);
    endfunction

endpackage

// File: rtl/pipe_add_stage.sv
// pipe_add_stage: one chunk-add register stage of pipe_add_rv.
// Adds operand chunk IDX plus the incoming carry, replaces those bits of the running
// word with the partial sum, and forwards the untouched bits and operand B.
// KEEP_CARRY=0 removes the carry register (used for the final stage when cout is absent).
module pipe_add_stage
    import pipe_add_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CW         = 16,
    parameter int IDX        = 0,
    parameter bit KEEP_CARRY = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_sum,
    input  logic [WIDTH-1:0] prev_b,
    input  logic             prev_carry,
    input  logic             next_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] b,
    output logic             carry
);

    localparam int LO = chunk_lo(WIDTH, CW, IDX);
    localparam int HI = chunk_hi(WIDTH, CW, IDX);
    localparam int NB = HI - LO;

    logic [WIDTH-1:0] sum_d;

    // An empty stage, or one whose item is leaving, can take a new item.
    assign ready = !valid || next_ready;

    if (NB == 0) begin : g_empty
        // Chunk lies past the top bit: pass the word and carry through unchanged.
        always_comb begin
            sum_d = prev_sum;
        end

        // Carry register keeps the final carry aligned with its sum.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                carry <= 1'b0;
            end else if (ready && prev_valid) begin
                carry <= prev_carry;
            end
        end
    end else if (KEEP_CARRY) begin : g_carry
        logic [NB:0] chunk;
        logic [NB:0] cin;

        // Chunk add with carry out; the low bits replace the operand A chunk in the word.
        // NOTE: every always_comb output gets a full default first so no latch is inferred.
        always_comb begin
            cin             = '0;
            cin[0]          = prev_carry;
            chunk           = {1'b0, prev_sum[HI-1:LO]} + {1'b0, prev_b[HI-1:LO]} + cin;
            sum_d           = prev_sum;
            sum_d[HI-1:LO]  = chunk[NB-1:0];
        end

        // Carry register feeding the next chunk (or cout on the final stage).
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                carry <= 1'b0;
            end else if (ready && prev_valid) begin
                carry <= chunk[NB];
            end
        end
    end else begin : g_nocarry
        logic [NB-1:0] chunk;
        logic [NB-1:0] cin;

        // Chunk add that wraps; the carry out has no consumer here.
        always_comb begin
            cin            = '0;
            cin[0]         = prev_carry;
            chunk          = prev_sum[HI-1:LO] + prev_b[HI-1:LO] + cin;
            sum_d          = prev_sum;
            sum_d[HI-1:LO] = chunk;
        end

        assign carry = 1'b0;
    end

    // Stage register: follow upstream whenever ready; data moves only with a valid item.
    // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            sum   <= '0;
            b     <= '0;
        end else if (ready) begin
            valid <= prev_valid;
            if (prev_valid) begin
                sum <= sum_d;
                b   <= prev_b;
            end
        end
    end

endmodule

// File: rtl/pipe_add_rv.sv
// pipe_add_rv: parametrised carry-split pipelined adder with valid/ready flow control.
// p0 captures the operands; STAGES chunk stages each add CW bits and pass the carry on.
// Results leave in order with bubble-collapsing backpressure; no skid buffer.
// Optional macro PIPE_ADD_COUT_EN adds the cout port and the final carry register.
module pipe_add_rv
    import pipe_add_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PIPE_ADD_COUT_EN
    ,
    output logic             cout
`endif
);

    localparam int CW = chunk_width(WIDTH, STAGES);

`ifdef PIPE_ADD_COUT_EN
    localparam bit COUT_EN = 1'b1;
`else
    localparam bit COUT_EN = 1'b0;
`endif

    if (!params_legal(WIDTH, STAGES)) begin : g_param_check
        $error("pipe_add_rv: need WIDTH >= 1 and 1 <= STAGES <= WIDTH");
    end

    // Index 0 is p0; index k is chunk stage k.
    logic [STAGES:0]  valid_vec;
    logic [WIDTH-1:0] sum_pipe   [0:STAGES];
    logic [WIDTH-1:0] b_pipe     [0:STAGES];
    logic             carry_pipe [0:STAGES];
    logic             ready_pipe [1:STAGES];

    logic             p0_valid;
    logic [WIDTH-1:0] p0_a;
    logic [WIDTH-1:0] p0_b;
    logic             p0_ready;

    assign p0_ready = !p0_valid || ready_pipe[1];

    // Held low while reset is asserted; otherwise the p0 ready equation.
    assign in_ready = !rst && p0_ready;

    // Input register: captures the operand pair and its valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_valid <= 1'b0;
            p0_a     <= '0;
            p0_b     <= '0;
        end else if (p0_ready) begin
            p0_valid <= in_valid;
            if (in_valid) begin
                p0_a <= a;
                p0_b <= b;
            end
        end
    end

    assign valid_vec[0]  = p0_valid;
    assign sum_pipe[0]   = p0_a;
    assign b_pipe[0]     = p0_b;
    assign carry_pipe[0] = 1'b0;

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        logic next_ready;

        if (k == STAGES) begin : g_last
            assign next_ready = out_ready;
        end else begin : g_mid
            // Unrolled ready chain: downstream accepts unless it is full and stalled.
            assign next_ready = out_ready || !(&valid_vec[STAGES:k+1]);
        end

        pipe_add_stage #(
            .WIDTH      (WIDTH),
            .CW         (CW),
            .IDX        (k - 1),
            .KEEP_CARRY ((k < STAGES) || COUT_EN)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .prev_valid (valid_vec[k-1]),
            .prev_sum   (sum_pipe[k-1]),
            .prev_b     (b_pipe[k-1]),
            .prev_carry (carry_pipe[k-1]),
            .next_ready (next_ready),
            .ready      (ready_pipe[k]),
            .valid      (valid_vec[k]),
            .sum        (sum_pipe[k]),
            .b          (b_pipe[k]),
            .carry      (carry_pipe[k])
        );
    end

    assign c         = sum_pipe[STAGES];
    assign out_valid = valid_vec[STAGES];

`ifdef PIPE_ADD_COUT_EN
    assign cout = carry_pipe[STAGES];
`endif

endmodule

// File: tb/tb_pipe_add_rv.sv
// tb_pipe_add_rv: directed bench for pipe_add_rv.
// dut2 = 32-bit/2 stages (latency, stall, backpressure, reset), dut4 = 32-bit/4 stages,
// dut13 = 13-bit/3 stages (uneven chunks). Build with PIPE_ADD_COUT_EN to check cout too.
module tb_pipe_add_rv;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        co;
    } vec_t;

    typedef struct {
        logic [31:0] c;
        logic        co;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] p2_a = '0, p2_b = '0, p2_c;
    logic        p2_iv = 1'b0, p2_ir, p2_ov, p2_or = 1'b0;
    logic [31:0] p4_a = '0, p4_b = '0, p4_c;
    logic        p4_iv = 1'b0, p4_ir, p4_ov, p4_or = 1'b0;
    logic [12:0] n13_a = '0, n13_b = '0, n13_c;
    logic        n13_iv = 1'b0, n13_ir, n13_ov, n13_or = 1'b0;
`ifdef PIPE_ADD_COUT_EN
    logic        p2_co, p4_co, n13_co;
`endif

    pipe_add_rv #(.WIDTH(32), .STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .a(p2_a), .b(p2_b), .in_valid(p2_iv), .in_ready(p2_ir),
        .c(p2_c), .out_valid(p2_ov), .out_ready(p2_or)
`ifdef PIPE_ADD_COUT_EN
        , .cout(p2_co)
`endif
    );

    pipe_add_rv #(.WIDTH(32), .STAGES(4)) dut4 (
        .clk(clk), .rst(rst), .a(p4_a), .b(p4_b), .in_valid(p4_iv), .in_ready(p4_ir),
        .c(p4_c), .out_valid(p4_ov), .out_ready(p4_or)
`ifdef PIPE_ADD_COUT_EN
        , .cout(p4_co)
`endif
    );

    pipe_add_rv #(.WIDTH(13), .STAGES(3)) dut13 (
        .clk(clk), .rst(rst), .a(n13_a), .b(n13_b), .in_valid(n13_iv), .in_ready(n13_ir),
        .c(n13_c), .out_valid(n13_ov), .out_ready(n13_or)
`ifdef PIPE_ADD_COUT_EN
        , .cout(n13_co)
`endif
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One pair through dut2 with out_ready high; latency counts edges from the accepting edge.
    task automatic run_single2(input vec_t v, input string tag);
        int  n;
        bit  got;
        @(negedge clk);
        p2_a  = v.a;
        p2_b  = v.b;
        p2_iv = 1'b1;
        p2_or = 1'b1;
        #1 check({tag, "_in_ready"}, 64'(p2_ir), 64'd1);
        @(posedge clk);
        #1 p2_iv = 1'b0;
        n   = 1;
        got = 1'b0;
        while (!got && n < 10) begin
            if (p2_ov) got = 1'b1;
            else begin
                @(posedge clk);
                #1 n++;
            end
        end
        check({tag, "_latency"}, 64'(n), 64'd3);
        check({tag, "_c"}, 64'(p2_c), 64'(v.c));
`ifdef PIPE_ADD_COUT_EN
        check({tag, "_cout"}, 64'(p2_co), 64'(v.co));
`endif
        @(posedge clk);
        #1 check({tag, "_gone"}, 64'(p2_ov), 64'd0);
    endtask

    vec_t vecs[8];
    vec_t fill[4];
    vec_t s4[6];
    vec_t s13[6];
    logic [31:0] ra[10];
    logic [31:0] rb[10];
    exp_t q2[$];
    exp_t q4[$];
    exp_t q13[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0};
        vecs[1] = '{32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b1};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        vecs[4] = '{32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 1'b0};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[7] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};

        fill[0] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0};
        fill[1] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'h0001_FFFE, 1'b0};
        fill[2] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0};
        fill[3] = '{32'hFFFF_0000, 32'h0002_0000, 32'h0001_0000, 1'b1};

        // dut4 chunks are 8 bits: these ripple through several chunk boundaries.
        s4[0] = '{32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0};
        s4[1] = '{32'h00FF_FFFF, 32'h0000_0001, 32'h0100_0000, 1'b0};
        s4[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
        s4[3] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b1};
        s4[4] = '{32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0};
        s4[5] = '{32'h0101_0101, 32'h1010_1010, 32'h1111_1111, 1'b0};

        // dut13 chunks are bits [4:0], [9:5], [12:10].
        s13[0] = '{32'h1FFF, 32'h0001, 32'h0000, 1'b1};
        s13[1] = '{32'h001F, 32'h0001, 32'h0020, 1'b0};
        s13[2] = '{32'h03FF, 32'h0001, 32'h0400, 1'b0};
        s13[3] = '{32'h1FFF, 32'h1FFF, 32'h1FFE, 1'b1};
        s13[4] = '{32'h0C00, 32'h0400, 32'h1000, 1'b0};
        s13[5] = '{32'h1000, 32'h1000, 32'h0000, 1'b1};

        for (int i = 0; i < 10; i++) begin
            ra[i] = $urandom;
            rb[i] = $urandom;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(p2_ov), 64'd0);
        check("rst_c", 64'(p2_c), 64'd0);
        check("rst_in_ready", 64'(p2_ir), 64'd0);
        check("rst_in_ready4", 64'(p4_ir), 64'd0);
        check("rst_in_ready13", 64'(n13_ir), 64'd0);
`ifdef PIPE_ADD_COUT_EN
        check("rst_cout", 64'(p2_co), 64'd0);
`endif
        rst = 1'b0;
        #1 check("release_in_ready", 64'(p2_ir), 64'd1);
        check("release_in_ready13", 64'(n13_ir), 64'd1);

        // Single transactions from the vector table
        for (int i = 0; i < 8; i++) begin
            run_single2(vecs[i], $sformatf("vec%0d", i));
        end

        // Fill with out_ready low, hold while stalled, then transfer in and out on one edge
        begin
            int  k;
            bit  full;
            logic [31:0] held;
            k    = 0;
            full = 1'b0;
            @(negedge clk);
            p2_or = 1'b0;
            for (int i = 0; i < 6 && !full; i++) begin
                if (i > 0) @(negedge clk);
                p2_a  = fill[k].a;
                p2_b  = fill[k].b;
                p2_iv = 1'b1;
                #1;
                if (p2_ir) begin
                    @(posedge clk);
                    k++;
                end else full = 1'b1;
            end
            check("fill_count", 64'(k), 64'd3);
            check("full_in_ready", 64'(p2_ir), 64'd0);
            check("full_out_valid", 64'(p2_ov), 64'd1);
            check("full_c", 64'(p2_c), 64'(fill[0].c));
            held = p2_c;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                #1;
                check("stall_c_stable", 64'(p2_c), 64'(held));
                check("stall_valid_stable", 64'(p2_ov), 64'd1);
                check("stall_in_ready", 64'(p2_ir), 64'd0);
            end
            @(negedge clk);
            p2_or = 1'b1;
            #1 check("same_edge_in_ready", 64'(p2_ir), 64'd1);
            @(posedge clk);
            #1 p2_iv = 1'b0;
            check("same_edge_out_valid", 64'(p2_ov), 64'd1);
            check("same_edge_c", 64'(p2_c), 64'(fill[1].c));
            k = 1;
            for (int i = 0; i < 10 && k < 4; i++) begin
                @(negedge clk);
                if (p2_ov) begin
                    check($sformatf("drain%0d", k), 64'(p2_c), 64'(fill[k].c));
`ifdef PIPE_ADD_COUT_EN
                    check($sformatf("drain%0d_cout", k), 64'(p2_co), 64'(fill[k].co));
`endif
                    k++;
                end
            end
            check("drain_count", 64'(k), 64'd4);
        end

        // Ten pairs with out_ready toggling at random
        begin
            int   sent, recv, cyc;
            bit   acc, dlv, hold;
            logic [31:0] hold_c;
            exp_t e;
            logic [32:0] s;
            sent = 0;
            recv = 0;
            cyc  = 0;
            hold = 1'b0;
            hold_c = '0;
            while (recv < 10 && cyc < 300) begin
                @(negedge clk);
                if (hold) begin
                    check("bp_c_stable", 64'(p2_c), 64'(hold_c));
                    check("bp_valid_stable", 64'(p2_ov), 64'd1);
                end
                p2_or = 1'($urandom_range(0, 1));
                if (sent < 10) begin
                    p2_a  = ra[sent];
                    p2_b  = rb[sent];
                    p2_iv = 1'b1;
                end else p2_iv = 1'b0;
                #1;
                acc  = p2_iv && p2_ir;
                dlv  = p2_ov && p2_or;
                hold = p2_ov && !p2_or;
                hold_c = p2_c;
                if (dlv) begin
                    if (q2.size() == 0) check("bp_extra_result", 64'd1, 64'd0);
                    else begin
                        e = q2.pop_front();
                        check($sformatf("bp_result%0d", recv), 64'(p2_c), 64'(e.c));
`ifdef PIPE_ADD_COUT_EN
                        check($sformatf("bp_cout%0d", recv), 64'(p2_co), 64'(e.co));
`endif
                    end
                    recv++;
                end
                if (acc) begin
                    s = {1'b0, ra[sent]} + {1'b0, rb[sent]};
                    q2.push_back('{s[31:0], s[32], cyc});
                    sent++;
                end
                @(posedge clk);
                cyc++;
            end
            @(negedge clk);
            p2_iv = 1'b0;
            p2_or = 1'b1;
            check("bp_recv_count", 64'(recv), 64'd10);
            check("bp_queue_empty", 64'(q2.size()), 64'd0);
        end

        // Continuous streams through dut4 and dut13: one result per cycle at fixed latency
        begin
            exp_t e;
            logic [32:0] s32;
            logic [13:0] s14;
            logic [31:0] x, y;
            logic [12:0] u, w;
            p4_or  = 1'b1;
            n13_or = 1'b1;
            for (int t = 0; t < 36; t++) begin
                @(negedge clk);
                if (p4_ov) begin
                    if (q4.size() == 0) check("s4_extra_result", 64'd1, 64'd0);
                    else begin
                        e = q4.pop_front();
                        check("s4_c", 64'(p4_c), 64'(e.c));
                        check("s4_latency", 64'(t - e.t), 64'd5);
`ifdef PIPE_ADD_COUT_EN
                        check("s4_cout", 64'(p4_co), 64'(e.co));
`endif
                    end
                end
                if (n13_ov) begin
                    if (q13.size() == 0) check("s13_extra_result", 64'd1, 64'd0);
                    else begin
                        e = q13.pop_front();
                        check("s13_c", 64'(n13_c), 64'(e.c));
                        check("s13_latency", 64'(t - e.t), 64'd4);
`ifdef PIPE_ADD_COUT_EN
                        check("s13_cout", 64'(n13_co), 64'(e.co));
`endif
                    end
                end
                if (t < 24) begin
                    if (t < 6) begin
                        x = s4[t].a;
                        y = s4[t].b;
                        u = s13[t].a[12:0];
                        w = s13[t].b[12:0];
                        q4.push_back('{s4[t].c, s4[t].co, t});
                        q13.push_back('{s13[t].c, s13[t].co, t});
                    end else begin
                        x   = $urandom;
                        y   = $urandom;
                        u   = 13'($urandom_range(0, 8191));
                        w   = 13'($urandom_range(0, 8191));
                        s32 = {1'b0, x} + {1'b0, y};
                        s14 = {1'b0, u} + {1'b0, w};
                        q4.push_back('{s32[31:0], s32[32], t});
                        q13.push_back('{{19'd0, s14[12:0]}, s14[13], t});
                    end
                    p4_a   = x;
                    p4_b   = y;
                    p4_iv  = 1'b1;
                    n13_a  = u;
                    n13_b  = w;
                    n13_iv = 1'b1;
                    #1;
                    check("s4_in_ready", 64'(p4_ir), 64'd1);
                    check("s13_in_ready", 64'(n13_ir), 64'd1);
                end else begin
                    p4_iv  = 1'b0;
                    n13_iv = 1'b0;
                end
            end
            check("s4_all_received", 64'(q4.size()), 64'd0);
            check("s13_all_received", 64'(q13.size()), 64'd0);
        end

        // Reset with three results in flight
        @(negedge clk);
        p2_or = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            p2_a  = fill[i].a;
            p2_b  = fill[i].b;
            p2_iv = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        p2_iv = 1'b0;
        check("pre_reset_out_valid", 64'(p2_ov), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_reset_out_valid", 64'(p2_ov), 64'd0);
        check("mid_reset_c", 64'(p2_c), 64'd0);
        check("mid_reset_in_ready", 64'(p2_ir), 64'd0);
`ifdef PIPE_ADD_COUT_EN
        check("mid_reset_cout", 64'(p2_co), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", 64'(p2_ir), 64'd1);
        check("post_reset_out_valid", 64'(p2_ov), 64'd0);
        run_single2('{32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0}, "post_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
